// File: rtl/ground_pad_bank_pkg.sv
// Shared types and helpers for the ground-pad bank sequencer.
// Holds the sequencer state encoding and a highest-set-bit search.
package ground_pad_bank_pkg;

  localparam int unsigned MAX_CH = 32;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAMP_UP   = 3'd1,
    ST_ON        = 3'd2,
    ST_RAMP_DOWN = 3'd3,
    ST_FAULT     = 3'd4
  } state_e;

  // Index of the highest set bit; 0 when the vector is empty.
  function automatic int unsigned highest_set(input logic [MAX_CH-1:0] v);
    highest_set = 0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (v[i]) highest_set = i;
    end
  endfunction

endpackage

// File: rtl/ground_pad_fault_sync.sv
// Multi-stage synchroniser bringing the asynchronous per-channel fault
// indications into the sequencer clock domain.
module ground_pad_fault_sync #(
  parameter int unsigned NCH         = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] fault_async,
  output logic [NCH-1:0] fault_sync
);

  logic [SYNC_STAGES-1:0][NCH-1:0] stage;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the pre-edge value of its predecessor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage <= {stage[SYNC_STAGES-2:0], fault_async};
    end
  end

  assign fault_sync = stage[SYNC_STAGES-1];

endmodule

// File: rtl/ground_pad_bank_seq.sv
// Staggered sequencer for a bank of ground-pad core switches: closes them
// one by one, opens them in reverse, and trips all of them on any fault.
module ground_pad_bank_seq
  import ground_pad_bank_pkg::*;
#(
  parameter int unsigned NCH         = 4,
  parameter int unsigned STAGGER     = 8,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned IW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           CLK,
  input  logic           RESET_B,
  input  logic           EN,
  input  logic [NCH-1:0] CH_MASK,
  input  logic [NCH-1:0] FAULT,
  input  logic           FAULT_CLR,
  output logic [NCH-1:0] SW_EN,
  output logic           READY,
  output logic           BUSY,
  output logic [NCH-1:0] FAULT_STS,
  output logic [IW-1:0]  CUR_CH
);

  localparam int unsigned CW = $clog2(STAGGER + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(STAGGER - 1);
  localparam logic [IW-1:0] LAST_CH  = IW'(NCH - 1);

  state_e         state_q, state_d;
  logic [NCH-1:0] sw_en_q, sw_en_d;
  logic [NCH-1:0] sts_q, sts_d;
  logic [NCH-1:0] mask_q, mask_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           last_q, last_d;
  logic           ready_q, busy_q;

  logic [NCH-1:0] fault_s;
  logic [NCH-1:0] hit;
  logic [IW-1:0]  top_idx;
  logic [NCH-1:0] down_sw_en;
  logic [IW-1:0]  down_idx;
  logic [CW-1:0]  down_cnt;

  ground_pad_fault_sync #(
    .NCH        (NCH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_fault_sync (
    .clk        (CLK),
    .rst_n      (RESET_B),
    .fault_async(FAULT),
    .fault_sync (fault_s)
  );

  // Only a fault on a closed switch matters; open channels are ignored.
  assign hit     = fault_s & sw_en_q;
  assign top_idx = IW'(highest_set(MAX_CH'(sw_en_q)));

  // Entry into ramp-down opens the highest closed switch on the same edge.
  always_comb begin
    down_sw_en = sw_en_q;
    down_idx   = top_idx;
    down_cnt   = '0;
    if (sw_en_q != '0) begin
      down_sw_en[top_idx] = 1'b0;
      down_cnt            = CNT_LOAD;
      down_idx            = (top_idx != '0) ? top_idx - IW'(1) : '0;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    sw_en_d = sw_en_q;
    sts_d   = sts_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    last_d  = last_q;

    if (hit != '0) begin
      state_d = ST_FAULT;
      sw_en_d = '0;
      sts_d   = sts_q | hit;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          sw_en_d = '0;
          if (EN) begin
            state_d = ST_RAMP_UP;
            mask_d  = CH_MASK;
            idx_d   = '0;
            cnt_d   = '0;
            last_d  = 1'b0;
          end
        end

        ST_RAMP_UP: begin
          if (!EN) begin
            state_d = ST_RAMP_DOWN;
            sw_en_d = down_sw_en;
            idx_d   = down_idx;
            cnt_d   = down_cnt;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else if (last_q) begin
            state_d = ST_ON;
          end else if (mask_q[idx_q]) begin
            sw_en_d[idx_q] = 1'b1;
            cnt_d          = CNT_LOAD;
            if (idx_q == LAST_CH) last_d = 1'b1;
            else                  idx_d  = idx_q + IW'(1);
          end else if (idx_q == LAST_CH) begin
            state_d = ST_ON;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end

        ST_ON: begin
          if (!EN) begin
            state_d = ST_RAMP_DOWN;
            sw_en_d = down_sw_en;
            idx_d   = down_idx;
            cnt_d   = down_cnt;
          end
        end

        ST_RAMP_DOWN: begin
          // EN is deliberately ignored here; the bank always finishes opening.
          if (sw_en_q == '0) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else if (sw_en_q[idx_q]) begin
            sw_en_d[idx_q] = 1'b0;
            cnt_d          = CNT_LOAD;
            if (idx_q != '0) idx_d = idx_q - IW'(1);
          end else begin
            idx_d = idx_q - IW'(1);
          end
        end

        ST_FAULT: begin
          sw_en_d = '0;
          if (FAULT_CLR && !EN) begin
            state_d = ST_IDLE;
            sts_d   = '0;
          end
        end

        default: begin
          state_d = ST_IDLE;
          sw_en_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      state_q <= ST_IDLE;
      sw_en_q <= '0;
      sts_q   <= '0;
      mask_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sw_en_q <= sw_en_d;
      sts_q   <= sts_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      ready_q <= (state_d == ST_ON);
      busy_q  <= (state_d == ST_RAMP_UP) || (state_d == ST_RAMP_DOWN);
    end
  end

  assign SW_EN     = sw_en_q;
  assign READY     = ready_q;
  assign BUSY      = busy_q;
  assign FAULT_STS = sts_q;
  assign CUR_CH    = idx_q;

endmodule
